// File: rtl/id_ex_stage_pkg.sv
// Shared widths, control-bit positions, forwarding encodings and the ID/EX payload for the id_ex_stage slice.
package id_ex_stage_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned CTRL_W = 8;

  localparam int unsigned CTRL_REGWRITE = 7;
  localparam int unsigned CTRL_MEMTOREG = 6;
  localparam int unsigned CTRL_MEMREAD  = 5;
  localparam int unsigned CTRL_MEMWRITE = 4;
  localparam int unsigned CTRL_ALUSRC   = 3;
  localparam int unsigned CTRL_ALUOP_HI = 2;
  localparam int unsigned CTRL_ALUOP_LO = 1;
  localparam int unsigned CTRL_REGDST   = 0;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [CTRL_W-1:0] ctrl;
    logic              valid;
  } id_ex_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID-side inputs, MEM/WB writeback taps and EX-side outputs of the ID/EX boundary.
interface id_ex_stage_if;
  import id_ex_stage_pkg::*;

  logic [DATA_W-1:0] ID_RS_Data_i;
  logic [DATA_W-1:0] ID_RT_Data_i;
  logic [DATA_W-1:0] ID_Imm_i;
  logic [ADDR_W-1:0] ID_RS_Addr_i;
  logic [ADDR_W-1:0] ID_RT_Addr_i;
  logic [ADDR_W-1:0] ID_RD_Addr_i;
  logic [CTRL_W-1:0] ID_Ctrl_i;
  logic              MEM_RegWrite_i;
  logic [ADDR_W-1:0] MEM_RD_Addr_i;
  logic              WB_RegWrite_i;
  logic [ADDR_W-1:0] WB_RD_Addr_i;

  logic [DATA_W-1:0] EX_RS_Data_o;
  logic [DATA_W-1:0] EX_RT_Data_o;
  logic [DATA_W-1:0] EX_Imm_o;
  logic [ADDR_W-1:0] EX_RS_Addr_o;
  logic [ADDR_W-1:0] EX_RT_Addr_o;
  logic [ADDR_W-1:0] EX_RD_Addr_o;
  logic [CTRL_W-1:0] EX_Ctrl_o;
  logic              EX_Valid_o;
  logic [1:0]        ForwardA_o;
  logic [1:0]        ForwardB_o;
  logic              HazardStall_o;

  modport master (
    output ID_RS_Data_i, ID_RT_Data_i, ID_Imm_i, ID_RS_Addr_i, ID_RT_Addr_i, ID_RD_Addr_i,
           ID_Ctrl_i, MEM_RegWrite_i, MEM_RD_Addr_i, WB_RegWrite_i, WB_RD_Addr_i,
    input  EX_RS_Data_o, EX_RT_Data_o, EX_Imm_o, EX_RS_Addr_o, EX_RT_Addr_o, EX_RD_Addr_o,
           EX_Ctrl_o, EX_Valid_o, ForwardA_o, ForwardB_o, HazardStall_o
  );

  modport slave (
    input  ID_RS_Data_i, ID_RT_Data_i, ID_Imm_i, ID_RS_Addr_i, ID_RT_Addr_i, ID_RD_Addr_i,
           ID_Ctrl_i, MEM_RegWrite_i, MEM_RD_Addr_i, WB_RegWrite_i, WB_RD_Addr_i,
    output EX_RS_Data_o, EX_RT_Data_o, EX_Imm_o, EX_RS_Addr_o, EX_RT_Addr_o, EX_RD_Addr_o,
           EX_Ctrl_o, EX_Valid_o, ForwardA_o, ForwardB_o, HazardStall_o
  );

endinterface

// File: rtl/id_ex_stage_forward_unit.sv
// Combinational EX operand forwarding selects; MEM result beats WB result, bubbles never forward.
module forward_unit
  import id_ex_stage_pkg::*;
(
  input  logic              ex_valid_i,
  input  logic [ADDR_W-1:0] ex_rs_addr_i,
  input  logic [ADDR_W-1:0] ex_rt_addr_i,
  input  logic              mem_regwrite_i,
  input  logic [ADDR_W-1:0] mem_rd_addr_i,
  input  logic              wb_regwrite_i,
  input  logic [ADDR_W-1:0] wb_rd_addr_i,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o
);

  function automatic logic [1:0] fwd_select(input logic [ADDR_W-1:0] src);
    logic [1:0] sel;
    sel = FWD_REG;
    if (mem_regwrite_i && (mem_rd_addr_i != '0) && (mem_rd_addr_i == src)) begin
      sel = FWD_MEM;
    end else if (wb_regwrite_i && (wb_rd_addr_i != '0) && (wb_rd_addr_i == src)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

  always_comb begin
    fwd_a_o = FWD_REG;
    fwd_b_o = FWD_REG;
    if (ex_valid_i) begin
      fwd_a_o = fwd_select(ex_rs_addr_i);
      fwd_b_o = fwd_select(ex_rt_addr_i);
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and EX operand forwarding selects.
module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          stall_i,
  input  logic          flush_i,
  id_ex_stage_if.slave  bus
);

  id_ex_t ex_q;
  id_ex_t ex_d;
  id_ex_t id_pl;
  logic   hazard_stall;

  always_comb begin
    id_pl         = '0;
    id_pl.rs_data = bus.ID_RS_Data_i;
    id_pl.rt_data = bus.ID_RT_Data_i;
    id_pl.imm     = bus.ID_Imm_i;
    id_pl.rs_addr = bus.ID_RS_Addr_i;
    id_pl.rt_addr = bus.ID_RT_Addr_i;
    id_pl.rd_addr = bus.ID_RD_Addr_i;
    id_pl.ctrl    = bus.ID_Ctrl_i;
    id_pl.valid   = 1'b1;
  end

  // Load in EX whose destination is read by the instruction in ID.
  always_comb begin
    hazard_stall = ex_q.valid && ex_q.ctrl[CTRL_MEMREAD] && (ex_q.rt_addr != '0) &&
                   ((ex_q.rt_addr == bus.ID_RS_Addr_i) || (ex_q.rt_addr == bus.ID_RT_Addr_i)) &&
                   !stall_i;
  end

  always_comb begin
    ex_d = ex_q;
    if (flush_i || (!stall_i && hazard_stall)) begin
      ex_d       = id_pl;
      ex_d.ctrl  = '0;
      ex_d.valid = 1'b0;
    end else if (!stall_i) begin
      ex_d = id_pl;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  forward_unit u_forward_unit (
    .ex_valid_i     (ex_q.valid),
    .ex_rs_addr_i   (ex_q.rs_addr),
    .ex_rt_addr_i   (ex_q.rt_addr),
    .mem_regwrite_i (bus.MEM_RegWrite_i),
    .mem_rd_addr_i  (bus.MEM_RD_Addr_i),
    .wb_regwrite_i  (bus.WB_RegWrite_i),
    .wb_rd_addr_i   (bus.WB_RD_Addr_i),
    .fwd_a_o        (bus.ForwardA_o),
    .fwd_b_o        (bus.ForwardB_o)
  );

  assign bus.EX_RS_Data_o  = ex_q.rs_data;
  assign bus.EX_RT_Data_o  = ex_q.rt_data;
  assign bus.EX_Imm_o      = ex_q.imm;
  assign bus.EX_RS_Addr_o  = ex_q.rs_addr;
  assign bus.EX_RT_Addr_o  = ex_q.rt_addr;
  assign bus.EX_RD_Addr_o  = ex_q.rd_addr;
  assign bus.EX_Ctrl_o     = ex_q.ctrl;
  assign bus.EX_Valid_o    = ex_q.valid;
  assign bus.HazardStall_o = hazard_stall;

endmodule
